// File: rtl/tl_ul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tl_ul_pkg
// Brief    : Shared TL-UL opcodes, responder FSM state and D-response record.
// Revision : 1.0 - initial release
// ============================================================================
package tl_ul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [2:0]  size;
        logic [5:0]  source;
        logic        sink;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } d_resp_t;

    // Byte lanes a naturally aligned access of 2**size bytes occupies.
    function automatic logic [3:0] size_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            3'd0:    return 4'b0001 << addr_lo;
            3'd1:    return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_ul_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : tl_ul_responder_if
// Brief    : TL-UL A/D channel bundle with requester (master) and responder
//            (slave) views.
// Revision : 1.0 - initial release
// ============================================================================
interface tl_ul_responder_if;
    logic        tlport_a_valid;
    logic        tlport_a_ready;
    logic [2:0]  tlport_a_bits_opcode;
    logic [2:0]  tlport_a_bits_param;
    logic [2:0]  tlport_a_bits_size;
    logic [5:0]  tlport_a_bits_source;
    logic [31:0] tlport_a_bits_address;
    logic [3:0]  tlport_a_bits_mask;
    logic [31:0] tlport_a_bits_data;
    logic        tlport_a_bits_corrupt;

    logic        tlport_d_valid;
    logic        tlport_d_ready;
    logic [2:0]  tlport_d_bits_opcode;
    logic [1:0]  tlport_d_bits_param;
    logic [2:0]  tlport_d_bits_size;
    logic [5:0]  tlport_d_bits_source;
    logic        tlport_d_bits_sink;
    logic        tlport_d_bits_denied;
    logic [31:0] tlport_d_bits_data;
    logic        tlport_d_bits_corrupt;

    modport master (
        output tlport_a_valid, tlport_a_bits_opcode, tlport_a_bits_param, tlport_a_bits_size,
               tlport_a_bits_source, tlport_a_bits_address, tlport_a_bits_mask,
               tlport_a_bits_data, tlport_a_bits_corrupt, tlport_d_ready,
        input  tlport_a_ready, tlport_d_valid, tlport_d_bits_opcode, tlport_d_bits_param,
               tlport_d_bits_size, tlport_d_bits_source, tlport_d_bits_sink,
               tlport_d_bits_denied, tlport_d_bits_data, tlport_d_bits_corrupt
    );

    modport slave (
        input  tlport_a_valid, tlport_a_bits_opcode, tlport_a_bits_param, tlport_a_bits_size,
               tlport_a_bits_source, tlport_a_bits_address, tlport_a_bits_mask,
               tlport_a_bits_data, tlport_a_bits_corrupt, tlport_d_ready,
        output tlport_a_ready, tlport_d_valid, tlport_d_bits_opcode, tlport_d_bits_param,
               tlport_d_bits_size, tlport_d_bits_source, tlport_d_bits_sink,
               tlport_d_bits_denied, tlport_d_bits_data, tlport_d_bits_corrupt
    );
endinterface
`default_nettype wire

// File: rtl/tl_ul_resp_mem.sv
`default_nettype none
// ============================================================================
// Module   : tl_ul_resp_mem
// Brief    : Single-port DEPTH x 32 storage, byte write enables, async read.
// Revision : 1.0 - initial release
// ============================================================================
module tl_ul_resp_mem #(
    parameter int DEPTH = 256
) (
    input  wire                       sys_clk,
    input  wire [$clog2(DEPTH)-1:0]   i_addr,
    input  wire [3:0]                 i_be,
    input  wire [31:0]                i_wdata,
    output logic [31:0]               o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Contents are intentionally left unreset.
    always_ff @(posedge sys_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/tl_ul_responder.sv
`default_nettype none
// ============================================================================
// Module   : tl_ul_responder
// Brief    : TL-UL manager endpoint backed by DEPTH words of storage.
//            Define TL_UL_RESP_PARTIAL_EN to enable PutPartialData/byte masks.
// Revision : 1.0 - initial release
// ============================================================================
module tl_ul_responder
    import tl_ul_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h6000_0000
) (
    input wire                sys_clk,
    input wire                rst,
    tl_ul_responder_if.slave  bus
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [32:0] c_SPAN = 33'(DEPTH) << 2;

    state_e      r_state_q, w_state_d;
    d_resp_t     r_resp_q,  w_resp_d;
    d_resp_t     w_resp;
    logic [31:0] w_offset;
    logic [31:0] w_rdata;
    logic [3:0]  w_be;
    logic [3:0]  w_we;
    logic        w_in_range, w_aligned, w_op_ok, w_mask_ok, w_denied;
    logic        w_is_get, w_is_put_full, w_is_put_partial, w_is_put;
    logic        w_a_ready, w_a_fire, w_d_fire;
    logic        w_unused_ok;

    assign w_unused_ok = ^bus.tlport_a_bits_param;

    // Lower-bound compare stops addresses below the base from wrapping into range.
    assign w_offset   = bus.tlport_a_bits_address - BASE_ADDR;
    assign w_in_range = (bus.tlport_a_bits_address >= BASE_ADDR) && ({1'b0, w_offset} < c_SPAN);

    always_comb begin
        w_aligned = 1'b0;
        case (bus.tlport_a_bits_size)
            3'd0:    w_aligned = 1'b1;
            3'd1:    w_aligned = ~bus.tlport_a_bits_address[0];
            3'd2:    w_aligned = (bus.tlport_a_bits_address[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_is_get         = (bus.tlport_a_bits_opcode == GET);
    assign w_is_put_full    = (bus.tlport_a_bits_opcode == PUT_FULL);
    assign w_is_put_partial = (bus.tlport_a_bits_opcode == PUT_PARTIAL);
    assign w_is_put         = w_is_put_full | w_is_put_partial;

`ifdef TL_UL_RESP_PARTIAL_EN
    assign w_op_ok   = w_is_get | w_is_put_full | w_is_put_partial;
    assign w_mask_ok = 1'b1;
    assign w_be      = bus.tlport_a_bits_mask;
`else
    assign w_op_ok   = w_is_get | w_is_put_full;
    assign w_mask_ok = ~w_is_put_full ||
                       (bus.tlport_a_bits_mask == size_mask(bus.tlport_a_bits_size,
                                                            bus.tlport_a_bits_address[1:0]));
    assign w_be      = size_mask(bus.tlport_a_bits_size, bus.tlport_a_bits_address[1:0]);
`endif

    assign w_denied = ~w_in_range || (bus.tlport_a_bits_size > 3'd2) || ~w_aligned || ~w_op_ok ||
                      ~w_mask_ok || (w_is_put && bus.tlport_a_bits_corrupt);

    assign w_a_ready = (r_state_q == ST_IDLE) | bus.tlport_d_ready;
    assign w_a_fire  = bus.tlport_a_valid & w_a_ready;
    assign w_d_fire  = (r_state_q == ST_RESP) & bus.tlport_d_ready;
    assign w_we      = (w_a_fire && w_is_put && !w_denied && !rst) ? w_be : 4'b0000;

    tl_ul_resp_mem #(.DEPTH(DEPTH)) u_mem (
        .sys_clk (sys_clk),
        .i_addr  (w_offset[AW+1:2]),
        .i_be    (w_we),
        .i_wdata (bus.tlport_a_bits_data),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_resp         = '0;
        w_resp.opcode  = w_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        w_resp.size    = bus.tlport_a_bits_size;
        w_resp.source  = bus.tlport_a_bits_source;
        w_resp.denied  = w_denied;
        w_resp.data    = (w_is_get && !w_denied) ? w_rdata : 32'h0;
        w_resp.corrupt = w_is_get & w_denied;
    end

    always_comb begin
        w_state_d = r_state_q;
        w_resp_d  = r_resp_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_a_fire) begin
                    w_state_d = ST_RESP;
                    w_resp_d  = w_resp;
                end
            end
            ST_RESP: begin
                if (w_a_fire) begin
                    w_resp_d  = w_resp;
                end else if (w_d_fire) begin
                    w_state_d = ST_IDLE;
                    w_resp_d  = '0;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_resp_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_resp_q  <= w_resp_d;
        end
    end

    assign bus.tlport_a_ready        = w_a_ready;
    assign bus.tlport_d_valid        = (r_state_q == ST_RESP);
    assign bus.tlport_d_bits_opcode  = r_resp_q.opcode;
    assign bus.tlport_d_bits_param   = r_resp_q.param;
    assign bus.tlport_d_bits_size    = r_resp_q.size;
    assign bus.tlport_d_bits_source  = r_resp_q.source;
    assign bus.tlport_d_bits_sink    = r_resp_q.sink;
    assign bus.tlport_d_bits_denied  = r_resp_q.denied;
    assign bus.tlport_d_bits_data    = r_resp_q.data;
    assign bus.tlport_d_bits_corrupt = r_resp_q.corrupt;

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_ul_responder
// Brief    : Directed table-driven bench for tl_ul_responder (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_ul_responder;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 sys_clk = ~sys_clk;

    tl_ul_responder_if bus_if ();

    tl_ul_responder dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus_if)
    );

`ifdef TL_UL_RESP_PARTIAL_EN
    localparam logic [31:0] c_W10     = 32'hDEAD_ABEF;
    localparam logic        c_PP_DENY = 1'b0;
`else
    localparam logic [31:0] c_W10     = 32'hDEAD_BEEF;
    localparam logic        c_PP_DENY = 1'b1;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  sz;
        logic [5:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        cor;
        logic [2:0]  e_op;
        logic        e_den;
        logic        e_cor;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [2:0] sz, input logic [5:0] src,
                           input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data, input logic cor);
        bus_if.tlport_a_valid        = 1'b1;
        bus_if.tlport_a_bits_opcode  = op;
        bus_if.tlport_a_bits_param   = 3'd0;
        bus_if.tlport_a_bits_size    = sz;
        bus_if.tlport_a_bits_source  = src;
        bus_if.tlport_a_bits_address = addr;
        bus_if.tlport_a_bits_mask    = mask;
        bus_if.tlport_a_bits_data    = data;
        bus_if.tlport_a_bits_corrupt = cor;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 3'd2, 6'd5,  32'h6000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 3'd0, 1'b0,      1'b0, 32'h0};
        vecs[1]  = '{3'd4, 3'd2, 6'd6,  32'h6000_0010, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0,      1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{3'd1, 3'd2, 6'd7,  32'h6000_0010, 4'h2, 32'h0000_AB00, 1'b0, 3'd0, c_PP_DENY, 1'b0, 32'h0};
        vecs[3]  = '{3'd4, 3'd2, 6'd8,  32'h6000_0010, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0,      1'b0, c_W10};
        vecs[4]  = '{3'd4, 3'd2, 6'd11, 32'h5FFF_FFFC, 4'hF, 32'h0,         1'b0, 3'd1, 1'b1,      1'b1, 32'h0};
        vecs[5]  = '{3'd4, 3'd2, 6'd12, 32'h6000_0400, 4'hF, 32'h0,         1'b0, 3'd1, 1'b1,      1'b1, 32'h0};
        vecs[6]  = '{3'd4, 3'd3, 6'd13, 32'h6000_0010, 4'hF, 32'h0,         1'b0, 3'd1, 1'b1,      1'b1, 32'h0};
        vecs[7]  = '{3'd0, 3'd2, 6'd14, 32'h6000_03FC, 4'hF, 32'h1234_5678, 1'b0, 3'd0, 1'b0,      1'b0, 32'h0};
        vecs[8]  = '{3'd4, 3'd2, 6'd15, 32'h6000_03FC, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0,      1'b0, 32'h1234_5678};
        vecs[9]  = '{3'd4, 3'd2, 6'd16, 32'h6000_0012, 4'hF, 32'h0,         1'b0, 3'd1, 1'b1,      1'b1, 32'h0};
        vecs[10] = '{3'd2, 3'd2, 6'd17, 32'h6000_0010, 4'hF, 32'h0,         1'b0, 3'd0, 1'b1,      1'b0, 32'h0};
        vecs[11] = '{3'd0, 3'd2, 6'd18, 32'h6000_0020, 4'hF, 32'h1111_1111, 1'b1, 3'd0, 1'b1,      1'b0, 32'h0};
        vecs[12] = '{3'd4, 3'd1, 6'd19, 32'h6000_0012, 4'h3, 32'h0,         1'b0, 3'd1, 1'b0,      1'b0, c_W10};

        bus_if.tlport_d_ready = 1'b1;
        drive_a(3'd0, 3'd0, 6'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        bus_if.tlport_a_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge sys_clk);
        chk("rst_d_valid", {31'b0, bus_if.tlport_d_valid}, 32'd0);
        chk("rst_a_ready", {31'b0, bus_if.tlport_a_ready}, 32'd1);
        chk("rst_d_opcode", {29'b0, bus_if.tlport_d_bits_opcode}, 32'd0);
        chk("rst_d_data", bus_if.tlport_d_bits_data, 32'd0);
        chk("rst_d_denied", {31'b0, bus_if.tlport_d_bits_denied}, 32'd0);
        rst = 1'b0;

        // Single-request vectors, each returning to IDLE
        for (int i = 0; i < 13; i++) begin
            @(negedge sys_clk);
            drive_a(vecs[i].op, vecs[i].sz, vecs[i].src, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].cor);
            @(negedge sys_clk);
            bus_if.tlport_a_valid = 1'b0;
            chk($sformatf("v%0d_d_valid", i), {31'b0, bus_if.tlport_d_valid}, 32'd1);
            chk($sformatf("v%0d_opcode", i), {29'b0, bus_if.tlport_d_bits_opcode}, {29'b0, vecs[i].e_op});
            chk($sformatf("v%0d_source", i), {26'b0, bus_if.tlport_d_bits_source}, {26'b0, vecs[i].src});
            chk($sformatf("v%0d_size", i), {29'b0, bus_if.tlport_d_bits_size}, {29'b0, vecs[i].sz});
            chk($sformatf("v%0d_denied", i), {31'b0, bus_if.tlport_d_bits_denied}, {31'b0, vecs[i].e_den});
            chk($sformatf("v%0d_corrupt", i), {31'b0, bus_if.tlport_d_bits_corrupt}, {31'b0, vecs[i].e_cor});
            chk($sformatf("v%0d_data", i), bus_if.tlport_d_bits_data, vecs[i].e_data);
        end

        // Back-pressure: response held for 5 cycles while another request waits
        @(negedge sys_clk);
        drive_a(3'd4, 3'd2, 6'd9, 32'h6000_0010, 4'hF, 32'h0, 1'b0);
        @(negedge sys_clk);
        bus_if.tlport_d_ready = 1'b0;
        drive_a(3'd4, 3'd2, 6'd10, 32'h6000_03FC, 4'hF, 32'h0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            chk("stall_d_valid", {31'b0, bus_if.tlport_d_valid}, 32'd1);
            chk("stall_source", {26'b0, bus_if.tlport_d_bits_source}, 32'd9);
            chk("stall_data", bus_if.tlport_d_bits_data, c_W10);
            chk("stall_a_ready", {31'b0, bus_if.tlport_a_ready}, 32'd0);
        end
        bus_if.tlport_d_ready = 1'b1;
        #1;
        chk("release_a_ready", {31'b0, bus_if.tlport_a_ready}, 32'd1);
        @(negedge sys_clk);
        bus_if.tlport_a_valid = 1'b0;
        chk("overlap_d_valid", {31'b0, bus_if.tlport_d_valid}, 32'd1);
        chk("overlap_source", {26'b0, bus_if.tlport_d_bits_source}, 32'd10);
        chk("overlap_data", bus_if.tlport_d_bits_data, 32'h1234_5678);
        @(negedge sys_clk);
        chk("overlap_idle", {31'b0, bus_if.tlport_d_valid}, 32'd0);

        // Eight back-to-back Gets
        for (int i = 0; i <= 8; i++) begin
            @(negedge sys_clk);
            if (i > 0) begin
                chk($sformatf("b2b%0d_d_valid", i - 1), {31'b0, bus_if.tlport_d_valid}, 32'd1);
                chk($sformatf("b2b%0d_source", i - 1), {26'b0, bus_if.tlport_d_bits_source}, 32'(20 + i - 1));
            end
            if (i < 8) drive_a(3'd4, 3'd2, 6'(20 + i), 32'h6000_0010, 4'hF, 32'h0, 1'b0);
            else       bus_if.tlport_a_valid = 1'b0;
        end
        @(negedge sys_clk);
        chk("b2b_end_idle", {31'b0, bus_if.tlport_d_valid}, 32'd0);

        // Reset while a response is held
        drive_a(3'd4, 3'd2, 6'd33, 32'h6000_0010, 4'hF, 32'h0, 1'b0);
        @(negedge sys_clk);
        bus_if.tlport_a_valid = 1'b0;
        bus_if.tlport_d_ready = 1'b0;
        chk("pre_rst_d_valid", {31'b0, bus_if.tlport_d_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_d_valid", {31'b0, bus_if.tlport_d_valid}, 32'd0);
        chk("rst_async_source", {26'b0, bus_if.tlport_d_bits_source}, 32'd0);
        @(negedge sys_clk);
        rst = 1'b0;
        bus_if.tlport_d_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            chk("post_rst_d_valid", {31'b0, bus_if.tlport_d_valid}, 32'd0);
        end
        drive_a(3'd4, 3'd2, 6'd34, 32'h6000_03FC, 4'hF, 32'h0, 1'b0);
        @(negedge sys_clk);
        bus_if.tlport_a_valid = 1'b0;
        chk("post_rst_new_valid", {31'b0, bus_if.tlport_d_valid}, 32'd1);
        chk("post_rst_new_data", bus_if.tlport_d_bits_data, 32'h1234_5678);
        @(negedge sys_clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tl_ul_responder.md
TL_UL_RESPONDER -- requirements
Module: tl_ul_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the number of 32-bit words of backing storage (power of 2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h6000_0000, giving the byte address of word 0.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port tlport_a_valid, input, 1: A-channel request valid.
REQ-006 SHALL have port tlport_a_ready, output, 1: A-channel accept.
REQ-007 SHALL have A-channel payload inputs with these widths: tlport_a_bits_opcode 3, tlport_a_bits_param 3, tlport_a_bits_size 3, tlport_a_bits_source 6, tlport_a_bits_address 32, tlport_a_bits_mask 4, tlport_a_bits_data 32, tlport_a_bits_corrupt 1.
REQ-008 SHALL have port tlport_d_valid, output, 1: D-channel response valid.
REQ-009 SHALL have port tlport_d_ready, input, 1: D-channel accept.
REQ-010 SHALL have D-channel payload outputs with these widths: tlport_d_bits_opcode 3, tlport_d_bits_param 2, tlport_d_bits_size 3, tlport_d_bits_source 6, tlport_d_bits_sink 1, tlport_d_bits_denied 1, tlport_d_bits_data 32, tlport_d_bits_corrupt 1.

Function
REQ-011 SHALL implement the TL-UL responder (manager) end: A fires when a_valid and a_ready are both 1; D fires when d_valid and d_ready are both 1.
REQ-012 SHALL use a two-state FSM: IDLE (no response held) -> RESP on A fire; RESP -> IDLE on D fire without a simultaneous A fire; RESP -> RESP when D and A fire in the same cycle.
REQ-013 SHALL drive a_ready = (state==IDLE) | d_ready, so back-to-back requests sustain one per cycle.
REQ-014 SHALL assert d_valid the cycle after A fires (latency 1) and hold the D payload stable until D fires.
REQ-015 SHALL treat a Get (opcode 4) as a read: d_opcode = 1 (AccessAckData), d_data = the addressed word.
REQ-016 SHALL treat PutFullData (0) and PutPartialData (1) as writes of a_data bytes where a_mask[i]=1: d_opcode = 0 (AccessAck), d_data = 0.
REQ-017 SHALL copy d_size and d_source from the accepted request, and drive d_param = 0 and d_sink = 0.
REQ-018 SHALL compute the word index as (address - BASE_ADDR) >> 2.
REQ-019 SHALL mark a request in range only if BASE_ADDR <= address < BASE_ADDR + 4*DEPTH; the subtraction has no wrap-around aliasing.
REQ-020 SHALL set d_denied = 1 with no storage write for any of: out-of-range address; size > 2; address misaligned to its size; opcode not in {0,1,4}; a_corrupt = 1 on a Put.
REQ-021 SHALL set d_corrupt = d_denied on an AccessAckData response and d_corrupt = 0 otherwise.
REQ-022 SHALL answer an unsupported opcode with d_opcode = 0.
REQ-023 SHALL commit a write in the A-fire cycle, so a Get accepted in the next cycle returns the new data.

Reset
REQ-024 SHALL, while rst = 1, force state = IDLE, d_valid = 0, a_ready = 1 (when d_ready = 1), and every D payload output to 0.
REQ-025 SHALL discard a held response when reset is asserted mid-operation, with no D fire after release.
REQ-026 SHALL leave storage contents unreset, so a read before any write returns an undefined value.

Configuration
REQ-027 SHALL compile in PutPartialData and byte-mask support when TL_UL_RESP_PARTIAL_EN is defined.
REQ-028 SHALL, when TL_UL_RESP_PARTIAL_EN is undefined, deny opcode 1 and deny any PutFullData whose mask is not all-ones for its size, and write full words only.

Structure
REQ-029 SHALL place the opcode constants (PUT_FULL, PUT_PARTIAL, GET, ACCESS_ACK, ACCESS_ACK_DATA), the FSM state typedef and the D-response struct in the shared package tl_ul_pkg.
REQ-030 SHALL instantiate storage as one sub-module, tl_ul_resp_mem, a single-port DEPTH x 32 array with byte write enables and a combinational read.

Verification
REQ-031 SHALL cover: PutFull addr 0x6000_0010, data 0xDEADBEEF, mask 0xF, source 5 -> next cycle d_valid, opcode 0, source 5, denied 0; then Get at the same address -> opcode 1, data 0xDEADBEEF.
REQ-032 SHALL cover: PutPartial mask 0x2, data 0x0000AB00 to the same word -> subsequent Get returns 0xDEADABEF (with TL_UL_RESP_PARTIAL_EN); without the macro -> denied 1 and the word is unchanged.
REQ-033 SHALL cover: Get at 0x5FFF_FFFC and at BASE + 4*DEPTH -> denied 1, corrupt 1; Get with size 3 -> denied 1.
REQ-034 SHALL cover: d_ready held 0 for 5 cycles with a response pending -> payload stable, a_ready 0; d_ready 1 with a_valid 1 -> both fire in the same cycle and the next response appears the following cycle.
REQ-035 SHALL cover: 8 back-to-back Gets with d_ready = 1 -> 8 responses in 8 consecutive cycles, sources in order.
REQ-036 SHALL cover: rst pulsed while d_valid = 1 -> d_valid drops immediately and stays 0 after release until a new A fire.
